// File: rtl/vga_timing_gen.sv
// Runtime-reprogrammable raster timing generator: counters, sync, data enable, strobes and row lookahead.
// New timing arrives over a valid/ready port and is swapped in only at the frame wrap.
module vga_timing_gen #(
   parameter int unsigned CORDW     = 12,
   parameter int unsigned LOOKAHEAD = 2,
   parameter int unsigned HA_END    = 1279,
   parameter int unsigned HS_STA    = 1287,
   parameter int unsigned HS_END    = 1319,
   parameter int unsigned LINE      = 1359,
   parameter int unsigned VA_END    = 719,
   parameter int unsigned VS_STA    = 726,
   parameter int unsigned VS_END    = 734,
   parameter int unsigned SCREEN    = 740,
   parameter bit          HS_POL    = 1'b0,
   parameter bit          VS_POL    = 1'b0
) (
   input  logic                          clk_pix,
   input  logic                          rst_pix_n,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [CORDW-1:0]              cfg_ha_end,
   input  logic [CORDW-1:0]              cfg_hs_sta,
   input  logic [CORDW-1:0]              cfg_hs_end,
   input  logic [CORDW-1:0]              cfg_line,
   input  logic [CORDW-1:0]              cfg_va_end,
   input  logic [CORDW-1:0]              cfg_vs_sta,
   input  logic [CORDW-1:0]              cfg_vs_end,
   input  logic [CORDW-1:0]              cfg_screen,
   input  logic                          cfg_hs_pol,
   input  logic                          cfg_vs_pol,
   output logic [CORDW-1:0]              sx,
   output logic [CORDW-1:0]              sy,
   output logic [LOOKAHEAD*CORDW-1:0]    sy_ahead,
   output logic                          hsync,
   output logic                          vsync,
   output logic                          de,
   output logic                          line,
   output logic                          frame,
   output logic                          cfg_applied
);

   typedef struct packed {
      logic [CORDW-1:0] ha_end;
      logic [CORDW-1:0] hs_sta;
      logic [CORDW-1:0] hs_end;
      logic [CORDW-1:0] line;
      logic [CORDW-1:0] va_end;
      logic [CORDW-1:0] vs_sta;
      logic [CORDW-1:0] vs_end;
      logic [CORDW-1:0] screen;
      logic             hs_pol;
      logic             vs_pol;
   } timing_t;

   typedef enum logic {ST_OPEN, ST_PENDING} cfg_state_t;

   localparam timing_t DEF_TIMING = '{
      ha_end: CORDW'(HA_END), hs_sta: CORDW'(HS_STA), hs_end: CORDW'(HS_END), line: CORDW'(LINE),
      va_end: CORDW'(VA_END), vs_sta: CORDW'(VS_STA), vs_end: CORDW'(VS_END), screen: CORDW'(SCREEN),
      hs_pol: HS_POL, vs_pol: VS_POL};

   timing_t    act_q;
   timing_t    pend_q;
   timing_t    cfg_in;
   cfg_state_t state_q;
   cfg_state_t state_d;

   logic h_wrap;
   logic v_wrap;
   logic f_wrap;
   logic xfer;
   logic apply;
   logic hs_act;
   logic vs_act;

   assign cfg_in = '{ha_end: cfg_ha_end, hs_sta: cfg_hs_sta, hs_end: cfg_hs_end, line: cfg_line,
                     va_end: cfg_va_end, vs_sta: cfg_vs_sta, vs_end: cfg_vs_end, screen: cfg_screen,
                     hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol};

   // >= rather than == so an out-of-range config still wraps immediately
   assign h_wrap = (sx >= act_q.line);
   assign v_wrap = (sy >= act_q.screen);
   assign f_wrap = h_wrap && v_wrap;
   assign xfer   = cfg_valid && cfg_ready;
   assign apply  = f_wrap && (state_q == ST_PENDING);
   assign hs_act = (sx >= act_q.hs_sta) && (sx < act_q.hs_end);
   assign vs_act = (sy >= act_q.vs_sta) && (sy < act_q.vs_end);

   // Pending-config tracker: open -> pending on capture, back to open when applied at frame wrap
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OPEN:    if (xfer)  state_d = ST_PENDING;
         ST_PENDING: if (apply) state_d = ST_OPEN;
         default:    state_d = ST_OPEN;
      endcase
   end

   always_ff @(posedge clk_pix) begin
      if (!rst_pix_n) begin
         state_q     <= ST_OPEN;
         cfg_ready   <= 1'b1;
         act_q       <= DEF_TIMING;
         pend_q      <= DEF_TIMING;
         sx          <= '0;
         sy          <= '0;
         for (int unsigned k = 0; k < LOOKAHEAD; k++)
            sy_ahead[k*CORDW +: CORDW] <= CORDW'(k + 1);
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         line        <= 1'b0;
         frame       <= 1'b0;
         cfg_applied <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_ready <= (state_d == ST_OPEN);
         if (xfer)  pend_q <= cfg_in;
         if (apply) act_q  <= pend_q;

         sx <= h_wrap ? '0 : sx + CORDW'(1);
         if (h_wrap) sy <= v_wrap ? '0 : sy + CORDW'(1);

         // Lookahead rows re-seed on a config swap since the new screen height may differ
         for (int unsigned k = 0; k < LOOKAHEAD; k++) begin
            if (apply)
               sy_ahead[k*CORDW +: CORDW] <= CORDW'(k + 1);
            else if (h_wrap)
               sy_ahead[k*CORDW +: CORDW] <= (sy_ahead[k*CORDW +: CORDW] >= act_q.screen) ?
                                             '0 : sy_ahead[k*CORDW +: CORDW] + CORDW'(1);
         end

         hsync       <= hs_act ? act_q.hs_pol : ~act_q.hs_pol;
         vsync       <= vs_act ? act_q.vs_pol : ~act_q.vs_pol;
         de          <= (sx <= act_q.ha_end) && (sy <= act_q.va_end);
         line        <= h_wrap;
         frame       <= f_wrap;
         cfg_applied <= apply;
      end
   end

endmodule
